// File: rtl/sdr_pkg.sv
// Shared definitions for the SDR control path: command bytes, tuning presets
// and steps, tuner FSM states and UART acknowledge bytes.
package sdr_pkg;

  localparam logic [7:0] CMD_GAIN0    = 8'h30;  // '0'
  localparam logic [7:0] CMD_GAIN1    = 8'h31;  // '1'
  localparam logic [7:0] CMD_GAIN2    = 8'h32;  // '2'
  localparam logic [7:0] CMD_GAIN3    = 8'h33;  // '3'
  localparam logic [7:0] CMD_PRESET_A = 8'h61;  // 'a'
  localparam logic [7:0] CMD_PRESET_B = 8'h62;  // 'b'
  localparam logic [7:0] CMD_PRESET_F = 8'h66;  // 'f'
  localparam logic [7:0] CMD_PRESET_G = 8'h67;  // 'g'
  localparam logic [7:0] CMD_UP_9K    = 8'h6d;  // 'm'
  localparam logic [7:0] CMD_DN_9K    = 8'h6e;  // 'n'
  localparam logic [7:0] CMD_UP_1K    = 8'h72;  // 'r'
  localparam logic [7:0] CMD_DN_1K    = 8'h71;  // 'q'
  localparam logic [7:0] CMD_UP_100   = 8'h70;  // 'p'
  localparam logic [7:0] CMD_DN_100   = 8'h6f;  // 'o'
  localparam logic [7:0] CMD_HEX      = 8'h78;  // 'x'

  localparam logic [7:0] ACK_OK  = 8'h6b;  // 'k'
  localparam logic [7:0] ACK_ERR = 8'h3f;  // '?'

  localparam logic [63:0] PRESET_A_DEF = 64'h4CF41F212D77318;
  localparam logic [63:0] PRESET_B_VAL = 64'h1aa60f8b8911654;
  localparam logic [63:0] PRESET_F_VAL = 64'h1dc38c076704516d;
  localparam logic [63:0] PRESET_G_VAL = 64'h1d60d923295482c6;

  localparam logic [63:0] STEP_9K_DEF   = 64'h71b375868d170;
  localparam logic [63:0] STEP_1K_DEF   = 64'hca22980ba57e;
  localparam logic [63:0] STEP_100_DEF  = 64'h1436a8cdf6f3;
  localparam logic [63:0] PHASE_MAX_DEF = 64'h2000000000000000;

  localparam int HEX_TIMEOUT_DEF = 8_000_000;

  typedef enum logic [1:0] {
    IDLE,
    HEX,
    APPLY,
    ACK
  } tuner_state_t;

endpackage

// File: rtl/hex_nibble_dec.sv
// ASCII hex digit decoder: '0'-'9', 'a'-'f', 'A'-'F' to a 4-bit value plus valid.
module hex_nibble_dec (
  input  logic [7:0] ascii,
  output logic [3:0] nibble,
  output logic       valid
);

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    nibble = 4'd0;
    valid  = 1'b0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      nibble = ascii[3:0];
      valid  = 1'b1;
    end else if ((ascii >= 8'h61 && ascii <= 8'h66) || (ascii >= 8'h41 && ascii <= 8'h46)) begin
      // Letters sit at 0x_1..0x_6 in both cases, so low nibble + 9 gives 10..15.
      nibble = ascii[3:0] + 4'd9;
      valid  = 1'b1;
    end
  end

endmodule

// File: rtl/tuner_ctrl.sv
// Command sequencer: decodes UART bytes into clamped NCO phase-increment and CIC gain
// updates. Define TUNER_ACK_EN to acknowledge each command over the UART transmitter.
module tuner_ctrl
  import sdr_pkg::*;
#(
  parameter int                 PHASE_W     = 64,
  parameter logic [PHASE_W-1:0] STEP_9K     = PHASE_W'(STEP_9K_DEF),
  parameter logic [PHASE_W-1:0] STEP_1K     = PHASE_W'(STEP_1K_DEF),
  parameter logic [PHASE_W-1:0] STEP_100    = PHASE_W'(STEP_100_DEF),
  parameter logic [PHASE_W-1:0] PHASE_MAX   = PHASE_W'(PHASE_MAX_DEF),
  parameter logic [PHASE_W-1:0] PRESET_A    = PHASE_W'(PRESET_A_DEF),
  parameter int                 HEX_TIMEOUT = HEX_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_dv,
  input  logic [7:0]         rx_byte,
  input  logic               tx_busy,
  output logic [PHASE_W-1:0] phase_inc,
  output logic [7:0]         cic_gain,
  output logic               cfg_stb
`ifdef TUNER_ACK_EN
  ,
  output logic               tx_start,
  output logic [7:0]         tx_byte
`endif
);

  localparam int               TMO_W = $clog2(HEX_TIMEOUT);
  localparam logic [PHASE_W:0] MAX_X = {1'b0, PHASE_MAX};
`ifdef TUNER_ACK_EN
  localparam tuner_state_t AFTER_APPLY = ACK;
`else
  localparam tuner_state_t AFTER_APPLY = IDLE;
`endif

  function automatic logic [PHASE_W-1:0] clamp_max(input logic [PHASE_W:0] v);
    return (v > MAX_X) ? PHASE_MAX : v[PHASE_W-1:0];
  endfunction

  tuner_state_t       state, state_nxt;
  logic               pend_valid;
  logic [7:0]         pend_byte;
  logic               can_take, cmd_valid;
  logic [7:0]         cmd_byte;
  logic [3:0]         nib;
  logic               nib_valid;
  logic [3:0]         digit_cnt;
  logic [59:0]        hex_shift;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [PHASE_W-1:0] apply_phase;
  logic [7:0]         apply_gain;
  logic               apply_is_gain;
  logic               go_apply, load_gain, hex_clear, hex_push, abort;
  logic [PHASE_W-1:0] load_phase;
  logic [7:0]         load_gain_val;
  logic [PHASE_W-1:0] step;
  logic [PHASE_W:0]   sum_up, diff_dn;

  // A byte held while busy is always consumed before the live strobe.
  assign can_take  = (state == IDLE) || (state == HEX);
  assign cmd_valid = can_take && (pend_valid || rx_dv);
  assign cmd_byte  = pend_valid ? pend_byte : rx_byte;

  hex_nibble_dec u_hex_dec (
    .ascii  (cmd_byte),
    .nibble (nib),
    .valid  (nib_valid)
  );

  always_comb begin
    step = '0;
    case (cmd_byte)
      CMD_UP_9K,  CMD_DN_9K:  step = STEP_9K;
      CMD_UP_1K,  CMD_DN_1K:  step = STEP_1K;
      CMD_UP_100, CMD_DN_100: step = STEP_100;
      default:                step = '0;
    endcase
  end

  // One extra bit catches both the borrow below zero and any excursion past the limit.
  assign sum_up  = {1'b0, phase_inc} + {1'b0, step};
  assign diff_dn = {1'b0, phase_inc} - {1'b0, step};

  always_comb begin
    state_nxt     = state;
    go_apply      = 1'b0;
    load_gain     = 1'b0;
    load_phase    = phase_inc;
    load_gain_val = cic_gain;
    hex_clear     = 1'b0;
    hex_push      = 1'b0;
    abort         = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        go_apply = 1'b1;
        case (cmd_byte)
          CMD_GAIN0, CMD_GAIN1, CMD_GAIN2, CMD_GAIN3: begin
            load_gain     = 1'b1;
            load_gain_val = {6'd0, cmd_byte[1:0]};
          end
          CMD_PRESET_A: load_phase = clamp_max({1'b0, PRESET_A});
          CMD_PRESET_B: load_phase = clamp_max((PHASE_W+1)'(PRESET_B_VAL));
          CMD_PRESET_F: load_phase = clamp_max((PHASE_W+1)'(PRESET_F_VAL));
          CMD_PRESET_G: load_phase = clamp_max((PHASE_W+1)'(PRESET_G_VAL));
          CMD_UP_9K, CMD_UP_1K, CMD_UP_100: load_phase = clamp_max(sum_up);
          CMD_DN_9K, CMD_DN_1K, CMD_DN_100:
            load_phase = diff_dn[PHASE_W] ? '0 : diff_dn[PHASE_W-1:0];
          CMD_HEX: begin
            go_apply  = 1'b0;
            hex_clear = 1'b1;
            state_nxt = HEX;
          end
          default: go_apply = 1'b0;
        endcase
        if (go_apply) state_nxt = APPLY;
      end
      HEX: begin
        if (cmd_valid) begin
          if (nib_valid) begin
            hex_push = 1'b1;
            if (digit_cnt == 4'd15) begin
              go_apply   = 1'b1;
              load_phase = clamp_max((PHASE_W+1)'({hex_shift, nib}));
              state_nxt  = APPLY;
            end
          end else begin
            abort     = 1'b1;
            state_nxt = AFTER_APPLY;
          end
        end else if (tmo_cnt == TMO_W'(HEX_TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = AFTER_APPLY;
        end
      end
      APPLY:   state_nxt = AFTER_APPLY;
      ACK:     if (!tx_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: clocked blocks use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid    <= 1'b0;
      pend_byte     <= 8'd0;
      digit_cnt     <= 4'd0;
      hex_shift     <= '0;
      tmo_cnt       <= '0;
      apply_phase   <= '0;
      apply_gain    <= 8'd0;
      apply_is_gain <= 1'b0;
      phase_inc     <= PRESET_A;
      cic_gain      <= 8'd0;
      cfg_stb       <= 1'b0;
    end else begin
      cfg_stb <= 1'b0;
      if (rx_dv && !can_take) begin
        pend_valid <= 1'b1;
        pend_byte  <= rx_byte;
      end else if (can_take && pend_valid) begin
        pend_valid <= rx_dv;
        if (rx_dv) pend_byte <= rx_byte;
      end
      if (hex_clear) begin
        digit_cnt <= 4'd0;
        hex_shift <= '0;
      end else if (hex_push) begin
        digit_cnt <= digit_cnt + 4'd1;
        hex_shift <= {hex_shift[55:0], nib};
      end
      if (state != HEX || cmd_valid) tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + 1'b1;
      if (go_apply) begin
        apply_phase   <= load_phase;
        apply_gain    <= load_gain_val;
        apply_is_gain <= load_gain;
      end
      if (state == APPLY) begin
        cfg_stb <= 1'b1;
        if (apply_is_gain) cic_gain  <= apply_gain;
        else               phase_inc <= apply_phase;
      end
    end
  end

`ifdef TUNER_ACK_EN
  logic ack_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_ok   <= 1'b0;
      tx_start <= 1'b0;
      tx_byte  <= 8'd0;
    end else begin
      tx_start <= 1'b0;
      if (go_apply)   ack_ok <= 1'b1;
      else if (abort) ack_ok <= 1'b0;
      if (state == ACK && !tx_busy) begin
        tx_start <= 1'b1;
        tx_byte  <= ack_ok ? ACK_OK : ACK_ERR;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tuner_ctrl.sv
// Self-checking bench for tuner_ctrl: directed corner cases plus randomized commands
// compared with an arithmetic model of the tuning rules.
module tb_tuner_ctrl;

  localparam int          TO   = 300;
  localparam logic [63:0] P_A  = 64'h4CF41F212D77318;
  localparam logic [63:0] P_B  = 64'h1aa60f8b8911654;
  localparam logic [63:0] P_F  = 64'h1dc38c076704516d;
  localparam logic [63:0] P_G  = 64'h1d60d923295482c6;
  localparam logic [63:0] S9   = 64'h71b375868d170;
  localparam logic [63:0] S1   = 64'hca22980ba57e;
  localparam logic [63:0] S100 = 64'h1436a8cdf6f3;
  localparam logic [63:0] PMAX = 64'h2000000000000000;

  logic        clk = 1'b0;
  logic        reset, rx_dv, tx_busy;
  logic [7:0]  rx_byte;
  logic [63:0] phase_inc;
  logic [7:0]  cic_gain;
  logic        cfg_stb;
`ifdef TUNER_ACK_EN
  logic        tx_start;
  logic [7:0]  tx_byte;
`endif

  tuner_ctrl #(.HEX_TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte),
    .tx_busy   (tx_busy),
    .phase_inc (phase_inc),
    .cic_gain  (cic_gain),
    .cfg_stb   (cfg_stb)
`ifdef TUNER_ACK_EN
    ,
    .tx_start  (tx_start),
    .tx_byte   (tx_byte)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] m_phase;
  logic [7:0]  m_gain;
  int          w_stb_cnt, w_stb_at, w_tx_cnt, w_tx_at;
  logic [7:0]  w_tx_val;
  int          r;
  logic [63:0] rv;
  logic [7:0]  cmd_set [14] = '{"0", "1", "2", "3", "a", "b", "f", "g",
                                "m", "n", "r", "q", "p", "o"};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lim(input logic [63:0] v);
    return (v > PMAX) ? PMAX : v;
  endfunction

  function automatic logic [63:0] step_dn(input logic [63:0] v, input logic [63:0] s);
    return (s > v) ? 64'd0 : v - s;
  endfunction

  task automatic model_cmd(input logic [7:0] b, output bit valid);
    valid = 1'b1;
    case (b)
      "0", "1", "2", "3": m_gain = b - 8'd48;
      "a": m_phase = lim(P_A);
      "b": m_phase = lim(P_B);
      "f": m_phase = lim(P_F);
      "g": m_phase = lim(P_G);
      "m": m_phase = lim(m_phase + S9);
      "n": m_phase = step_dn(m_phase, S9);
      "r": m_phase = lim(m_phase + S1);
      "q": m_phase = step_dn(m_phase, S1);
      "p": m_phase = lim(m_phase + S100);
      "o": m_phase = step_dn(m_phase, S100);
      default: valid = 1'b0;
    endcase
  endtask

  function automatic bit is_known(input logic [7:0] b);
    if (b == "x") return 1'b1;
    foreach (cmd_set[i]) if (cmd_set[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] junk_byte();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (is_known(b));
    return b;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (($urandom % 2) ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
  endfunction

  // Runs n cycles from a negedge, recording cfg_stb and tx_start activity.
  task automatic watch(input int n);
    w_stb_cnt = 0; w_stb_at = -1; w_tx_cnt = 0; w_tx_at = -1; w_tx_val = 8'd0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      rx_dv = 1'b0;
      if (cfg_stb) begin
        w_stb_cnt++;
        if (w_stb_at < 0) w_stb_at = i;
      end
`ifdef TUNER_ACK_EN
      if (tx_start) begin
        w_tx_cnt++;
        if (w_tx_at < 0) begin w_tx_at = i; w_tx_val = tx_byte; end
      end
`endif
    end
  endtask

  task automatic send(input logic [7:0] b, input int n);
    rx_byte = b;
    rx_dv   = 1'b1;
    watch(n);
  endtask

  task automatic cmd(input logic [7:0] b);
    bit valid;
    model_cmd(b, valid);
    send(b, 5);
    check("stb_count", w_stb_cnt, valid ? 1 : 0);
    if (valid) check("stb_latency", w_stb_at, 2);
    check("phase_inc", phase_inc, m_phase);
    check("cic_gain", cic_gain, m_gain);
`ifdef TUNER_ACK_EN
    check("ack_count", w_tx_cnt, valid ? 1 : 0);
    if (valid) begin
      check("ack_latency", w_tx_at, 3);
      check("ack_byte", w_tx_val, "k");
    end
`endif
  endtask

  task automatic hex_entry(input logic [63:0] val);
    cmd("x");
    for (int d = 15; d >= 0; d--) begin
      send(hex_char(val[d*4 +: 4]), (d == 0) ? 5 : 2);
      if (d != 0) check("hex_digit_stb", w_stb_cnt, 0);
    end
    m_phase = lim(val);
    check("hex_stb_count", w_stb_cnt, 1);
    check("hex_stb_latency", w_stb_at, 2);
    check("hex_phase", phase_inc, m_phase);
`ifdef TUNER_ACK_EN
    check("hex_ack_count", w_tx_cnt, 1);
    check("hex_ack_byte", w_tx_val, "k");
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_dv = 1'b0; rx_byte = 8'd0; tx_busy = 1'b0;
    m_phase = P_A; m_gain = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_phase", phase_inc, P_A);
    check("reset_gain", cic_gain, 0);
    check("reset_stb", cfg_stb, 0);
`ifdef TUNER_ACK_EN
    check("reset_tx_start", tx_start, 0);
    check("reset_tx_byte", tx_byte, 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    cmd("m");
    hex_entry(64'h1d60d923295482c6);
    hex_entry(64'hFFFFFFFFFFFFFFFF);

    // Clamp at the bottom and top, with a strobe on every step.
    hex_entry(64'h3000);
    repeat (3) cmd("o");
    cmd("n");
    hex_entry(PMAX - 64'd5);
    cmd("m");
    cmd("p");
    cmd("a");

    // Non-hex byte aborts the entry.
    cmd("x");
    send("7", 2);
    send("c", 2);
    send("z", 5);
    check("abort_stb", w_stb_cnt, 0);
    check("abort_phase", phase_inc, m_phase);
`ifdef TUNER_ACK_EN
    check("abort_ack_count", w_tx_cnt, 1);
    check("abort_ack_latency", w_tx_at, 2);
    check("abort_ack_byte", w_tx_val, "?");
`endif
    cmd("1");

    // Partial entry followed by silence times out.
    cmd("x");
    for (int i = 0; i < 5; i++) send(hex_char(4'(i + 9)), 2);
    watch(TO + 10);
    check("timeout_stb", w_stb_cnt, 0);
    check("timeout_phase", phase_inc, m_phase);
`ifdef TUNER_ACK_EN
    check("timeout_ack_count", w_tx_cnt, 1);
    check("timeout_ack_byte", w_tx_val, "?");
    check("timeout_ack_window", (w_tx_at >= TO - 2) && (w_tx_at <= TO + 2), 1);
`endif
    cmd("2");

    // Transmitter busy: ack is held, the next byte waits in the pending slot.
    tx_busy = 1'b1;
`ifdef TUNER_ACK_EN
    m_gain = 8'd1;
    send("1", 5);
    check("busy_stb_latency", w_stb_at, 2);
    check("busy_ack_held", w_tx_cnt, 0);
    check("busy_gain1", cic_gain, m_gain);
    send("3", 6);
    check("busy_pending_stb", w_stb_cnt, 0);
    check("busy_ack_held2", w_tx_cnt, 0);
    check("busy_gain_hold", cic_gain, m_gain);
    tx_busy = 1'b0;
    watch(8);
    m_gain = 8'd3;
    check("busy_ack_count", w_tx_cnt, 2);
    check("busy_ack_first", w_tx_at, 1);
    check("busy_ack_byte", w_tx_val, "k");
    check("busy_release_stb", w_stb_cnt, 1);
    check("busy_gain3", cic_gain, m_gain);
`else
    cmd("1");
    cmd("3");
    tx_busy = 1'b0;
`endif

    // Three bytes on consecutive cycles: one pending slot, latest wins.
    rx_byte = "1"; rx_dv = 1'b1;
    @(negedge clk); rx_byte = "2";
    @(negedge clk); rx_byte = "3";
    watch(12);
    m_gain = 8'd3;
    check("b2b_gain", cic_gain, m_gain);
`ifdef TUNER_ACK_EN
    check("b2b_stb_count", w_stb_cnt, 1);
`else
    check("b2b_stb_count", w_stb_cnt, 2);
`endif

    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 19);
      if (r < 2) begin
        rv = {$urandom, $urandom};
        if (r == 0) rv = rv >> 3;
        hex_entry(rv);
      end else if (r < 4) begin
        cmd(junk_byte());
      end else begin
        cmd(cmd_set[$urandom_range(0, 13)]);
      end
    end

    // Reset in the middle of a hex entry discards it.
    cmd("x");
    send("4", 2);
    send("5", 2);
    reset = 1'b1;
    @(negedge clk);
    m_phase = P_A; m_gain = 8'd0;
    check("midhex_reset_phase", phase_inc, m_phase);
    check("midhex_reset_gain", cic_gain, m_gain);
    check("midhex_reset_stb", cfg_stb, 0);
`ifdef TUNER_ACK_EN
    check("midhex_reset_tx_start", tx_start, 0);
    check("midhex_reset_tx_byte", tx_byte, 0);
`endif
    reset = 1'b0;
    @(negedge clk);
    cmd("z");
    cmd("1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
